// File: rtl/reg_bank_scan.sv
// reg_bank_scan
//   A 32 x 32-bit register bank with two combinational read ports, an
//   optional write-to-read bypass, a flat view of all stored registers,
//   and a scan engine that dumps every register in order over a
//   valid/ready stream.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   we, wa, wd        : write port (writes to register 0 are dropped)
//   ra1/rd1, ra2/rd2  : combinational read ports (bypass when BYPASS=1)
//   regs_flat         : stored state, register i at [32*i+31:32*i]
//   scan_start        : request a full dump (honoured only when idle)
//   scan_valid/ready  : scan stream handshake
//   scan_sel/data     : index and stored contents of the presented word
//   scan_busy         : high while a dump is in SEND or DONE
//   scan_done         : one-cycle pulse after the last word is accepted
//
// Handshake: a scan word transfers on every rising edge where
// scan_valid=1 and scan_ready=1. While scan_valid=1 and scan_ready=0 the
// index is held; scan_data always reflects the current stored value of
// that register, so a write during a stall shows up the following cycle.
//
// Scan FSM state is fully observable on the ports: IDLE when
// scan_busy=0, SEND when scan_valid=1, DONE when scan_done=1.

module reg_bank_scan #(
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [4:0]    wa,
  input  logic [31:0]   wd,
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2,
  output logic [1023:0] regs_flat,
  input  logic          scan_start,
  output logic          scan_valid,
  input  logic          scan_ready,
  output logic [4:0]    scan_sel,
  output logic [31:0]   scan_data,
  output logic          scan_busy,
  output logic          scan_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Entry 0 is reset to zero and never written, so it reads 0 everywhere.
  logic [31:0] r_mem [0:31];
  state_t      r_state;
  logic [4:0]  r_idx;

  state_t      w_state_nxt;
  logic [4:0]  w_idx_nxt;
  logic        w_xfer;

  // ---------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      r_mem[wa] <= wd;
    end
  end

  // Read ports: the address==wa match implies wa!=0 since addr 0 is
  // handled first.
  always_comb begin
    rd1 = '0;
    if (ra1 != 5'd0) begin
      if (BYPASS && we && (wa == ra1)) rd1 = wd;
      else                             rd1 = r_mem[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != 5'd0) begin
      if (BYPASS && we && (wa == ra2)) rd2 = wd;
      else                             rd2 = r_mem[ra2];
    end
  end

  // Flat view is stored state only; never bypassed.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 32; i++) begin
      regs_flat[32*i +: 32] = r_mem[i];
    end
  end

  // ---------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign w_xfer = (r_state == S_SEND) && scan_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    scan_valid  = 1'b0;
    scan_busy   = 1'b0;
    scan_done   = 1'b0;
    scan_sel    = '0;
    scan_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (scan_start) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        scan_valid = 1'b1;
        scan_busy  = 1'b1;
        scan_sel   = r_idx;
        scan_data  = r_mem[r_idx];
        if (w_xfer) begin
          if (r_idx == 5'd31) w_state_nxt = S_DONE;
          else                w_idx_nxt   = r_idx + 5'd1;
        end
      end
      S_DONE: begin
        // scan_start is ignored here; a held start restarts from IDLE.
        scan_busy   = 1'b1;
        scan_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/reg_bank_scan.md
REG_BANK_SCAN -- requirements
Module: reg_bank_scan

Interface
REQ-001 SHALL have one parameter, one per line: name, default, meaning.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = no forwarding.
REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- we, in, 1, write enable.
- wa, in, 5, write address.
- wd, in, 32, write data.
- ra1, in, 5, read address, port 1.
- ra2, in, 5, read address, port 2.
- rd1, out, 32, read data, port 1.
- rd2, out, 32, read data, port 2.
- regs_flat, out, 1024, all registers; register i at bits [32*i+31:32*i]; feeds a 32:1 32-bit selector as I0..I31.
- scan_start, in, 1, request a full register dump.
- scan_valid, out, 1, scan_sel/scan_data are presented.
- scan_ready, in, 1, consumer accepts the current scan word.
- scan_sel, out, 5, index of the presented register.
- scan_data, out, 32, contents of register scan_sel.
- scan_busy, out, 1, scan in progress.
- scan_done, out, 1, one-cycle pulse after the last word is accepted.

Function
REQ-003 SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-004 SHALL write wd into register wa at the rising edge when we=1 and wa!=0.
REQ-005 rd1/rd2 SHALL be combinational: 0 if the address is 0; else wd if BYPASS=1, we=1 and wa equals the address; else the stored value.
REQ-006 regs_flat SHALL reflect stored register state only, with no bypass; a write is visible the cycle after the edge.
REQ-007 The scan FSM SHALL have states IDLE, SEND and DONE, plus a 5-bit index idx.
REQ-008 IDLE: scan_valid=0, scan_busy=0. scan_start=1 SHALL load idx=0 and move to SEND.
REQ-009 SEND: scan_valid=1, scan_busy=1, scan_sel=idx, and scan_data = stored register[idx] (combinational, no bypass).
REQ-010 SEND: a transfer SHALL occur on a cycle with scan_valid=1 and scan_ready=1. On transfer with idx<31, idx increments; on transfer with idx=31, next state is DONE.
REQ-011 SEND with scan_ready=0 SHALL hold idx and keep scan_valid=1; a write to register idx during a stall SHALL appear on scan_data the next cycle.
REQ-012 DONE: scan_done=1 and scan_busy=1 for exactly one cycle, then IDLE; scan_valid=0.
REQ-013 scan_start SHALL be ignored in SEND and DONE; scan_start held high across DONE SHALL start a new scan from IDLE the following cycle.
REQ-014 Register writes SHALL proceed independently of scan state; a simultaneous write and scan transfer of the same register SHALL deliver the pre-write value.
REQ-015 Latency: start-to-first scan_valid is 1 cycle; a full dump with scan_ready held at 1 takes 32 SEND cycles plus 1 DONE cycle.

Reset
REQ-016 With rst=1 at an edge, all registers SHALL be set to 0, the state to IDLE and idx to 0; scan_valid, scan_busy and scan_done SHALL be 0, scan_sel 0, scan_data 0.
REQ-017 rst SHALL take priority over we and scan_start in the same cycle.
REQ-018 rst during SEND SHALL abort the scan without a scan_done pulse.

Verification
REQ-019 Write 0xDEADBEEF to reg 5 -> next cycle regs_flat[191:160]=0xDEADBEEF; ra1=5 gives rd1=0xDEADBEEF.
REQ-020 we=1, wa=0, wd=0xFFFFFFFF -> rd1 with ra1=0 stays 0; regs_flat[31:0]=0.
REQ-021 BYPASS=1, we=1, wa=ra2=7, wd=0x12345678 -> rd2=0x12345678 the same cycle, and regs_flat updates only after the edge.
REQ-022 Registers preloaded with value i, scan_ready=1, pulse scan_start -> 32 consecutive words (sel 0..31, data 0..31), then a single scan_done pulse, then scan_busy=0.
REQ-023 Random scan_ready stalls plus a write to the stalled index -> no index skipped or repeated, and updated data is presented after the write.
REQ-024 rst asserted at idx=10 -> the next cycle shows IDLE, all regs 0, scan_valid=0, and scan_done never asserted.
